// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the row DCT and the column DCT of a 2-D DCT.
// Rows are written into one bank while the other bank is replayed column by column.
module dct_transpose_buf #(
    parameter int BW   = 12,
    parameter int N    = 16,
    parameter int CNTW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*BW-1:0]   in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*BW-1:0]   out_col,
    output logic [CNTW-1:0]   out_col_idx,
    output logic              out_last
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(N - 1);

    // Each bank holds N packed rows; a column is gathered across rows on read.
    logic [N*BW-1:0] mem_q [2][N];

    logic            wr_bank_q, wr_bank_d;
    logic [CNTW-1:0] wr_row_q,  wr_row_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CNTW-1:0] rd_col_q,  rd_col_d;
    logic [1:0]      full_q,    full_d;

    logic wr_fire;
    logic rd_fire;

    // Handshake flags depend only on registered state, so no ready/valid loop forms.
    assign in_ready    = !full_q[wr_bank_q];
    assign out_valid   = full_q[rd_bank_q];
    assign wr_fire     = in_valid && in_ready;
    assign rd_fire     = out_valid && out_ready;
    assign out_col_idx = rd_col_q;
    assign out_last    = out_valid && (rd_col_q == LAST_IDX);

    always_comb begin
        // NOTE: every signal gets a default before the conditionals so no latch is inferred.
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        full_d    = full_q;

        if (wr_fire) begin
            if (wr_row_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_row_d          = '0;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end

        // The write bank is never full and the read bank always is, so they differ here.
        if (rd_fire) begin
            if (rd_col_q == LAST_IDX) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                rd_col_d          = '0;
            end else begin
                rd_col_d = rd_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
            full_q    <= full_d;
        end
    end

    // NOTE: word storage has no reset; the full bits alone decide what is ever read out.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_row_q] <= in_row;
        end
    end

    // Word r of the presented column comes from row r; zero whenever nothing is valid.
    always_comb begin
        out_col = '0;
        if (out_valid) begin
            for (int r = 0; r < N; r++) begin
                out_col[(N-1-r)*BW +: BW] = mem_q[rd_bank_q][r][(N-1-int'(rd_col_q))*BW +: BW];
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf: a transpose scoreboard fed by an input
// monitor, a vector table for the first block and directed multi-cycle corner cases.
module tb_dct_transpose_buf;

    localparam int BW   = 12;
    localparam int N    = 16;
    localparam int CNTW = 4;
    localparam int W    = N * BW;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_row = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_col;
    logic [CNTW-1:0] out_col_idx;
    logic            out_last;

    always #5 clk = ~clk;

    dct_transpose_buf #(.BW(BW), .N(N), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_col_idx(out_col_idx), .out_last(out_last)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0]    col;
        logic [CNTW-1:0] idx;
        logic            last;
    } exp_t;

    typedef struct {
        logic [CNTW-1:0] idx;
        logic [BW-1:0]   w0;
        logic [BW-1:0]   w15;
        logic            last;
    } vec_t;

    exp_t         sb[$];
    logic [W-1:0] blk_m [N];
    int           wr_cnt = 0;
    int           acc_count = 0;
    bit           src_done = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] word_of(input logic [W-1:0] v, input int k);
        return v[(N-1-k)*BW +: BW];
    endfunction

    function automatic logic [W-1:0] ramp_row(input int r, input int base);
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[(N-1-c)*BW +: BW] = BW'(base + r*N + c);
        return v;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
            case ($urandom % 8)
                0:       v[(N-1-c)*BW +: BW] = 12'h800;
                1:       v[(N-1-c)*BW +: BW] = 12'hFFF;
                default: v[(N-1-c)*BW +: BW] = BW'($urandom);
            endcase
        end
        return v;
    endfunction

    // Input monitor: every accepted row goes into the reference block; a completed
    // block pushes its 16 transposed columns onto the scoreboard.
    always @(negedge clk) begin : in_mon
        exp_t e;
        if (rstn && in_valid && in_ready) begin
            blk_m[wr_cnt] = in_row;
            acc_count++;
            if (wr_cnt == N-1) begin
                for (int c = 0; c < N; c++) begin
                    e.col = '0;
                    for (int r = 0; r < N; r++) e.col[(N-1-r)*BW +: BW] = word_of(blk_m[r], c);
                    e.idx  = CNTW'(c);
                    e.last = (c == N-1);
                    sb.push_back(e);
                end
                wr_cnt = 0;
            end else begin
                wr_cnt++;
            end
        end
    end

    // Output monitor: compares each column handshake and checks stability across stalls.
    logic [W-1:0]    prev_col;
    logic [CNTW-1:0] prev_idx;
    logic            prev_last;
    bit              prev_stall = 1'b0;

    always @(negedge clk) begin : out_mon
        exp_t e;
        if (rstn && prev_stall) begin
            check("stall out_col stable", out_col, prev_col);
            check("stall out_col_idx stable", W'(out_col_idx), W'(prev_idx));
            check("stall out_last stable", W'(out_last), W'(prev_last));
        end
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected column: idx %0d presented, scoreboard empty", out_col_idx);
            end else begin
                e = sb.pop_front();
                check("column data", out_col, e.col);
                check("column idx", W'(out_col_idx), W'(e.idx));
                check("column last", W'(out_last), W'(e.last));
            end
        end
        prev_stall = rstn && out_valid && !out_ready;
        prev_col   = out_col;
        prev_idx   = out_col_idx;
        prev_last  = out_last;
    end

    // Drives a row and holds it until accepted; returns 1 ns after the accepting edge.
    task automatic send_row(input logic [W-1:0] row);
        bit ok;
        ok       = 1'b0;
        in_row   = row;
        in_valid = 1'b1;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_row timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic drain_all();
        out_ready = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain scoreboard empty", W'(sb.size()), W'(0));
        @(negedge clk);
        check("drain out_valid low", W'(out_valid), W'(0));
        check("drain in_ready high", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t         vec [N];
        logic [W-1:0] tmp;
        int           gaps, drops, acc0, idle;

        for (int i = 0; i < N; i++) begin
            vec[i].idx  = CNTW'(i);
            vec[i].w0   = BW'(i);
            vec[i].w15  = BW'(240 + i);
            vec[i].last = (i == N-1);
        end

        // Reset state
        #12;
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset out_col", out_col, '0);
        check("reset out_col_idx", W'(out_col_idx), W'(0));
        check("reset out_last", W'(out_last), W'(0));
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single block, replayed against the vector table
        for (int r = 0; r < N-1; r++) send_row(ramp_row(r, 0));
        in_valid = 1'b0;
        @(negedge clk);
        check("no out_valid before block complete", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        send_row(ramp_row(N-1, 0));
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("table out_valid", W'(out_valid), W'(1));
            check("table idx", W'(out_col_idx), W'(vec[i].idx));
            check("table word row0", W'(out_col[W-1 -: BW]), W'(vec[i].w0));
            check("table word row15", W'(out_col[BW-1:0]), W'(vec[i].w15));
            check("table last", W'(out_last), W'(vec[i].last));
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        @(negedge clk);
        check("single block drained", W'(out_valid), W'(0));
        @(posedge clk);
        #1;

        // Streaming: four blocks back to back with the sink always ready
        gaps      = 0;
        drops     = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 4*N; i++) send_row(rand_row());
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (!in_ready) drops++;
                    if (out_valid) break;
                end
                for (int i = 0; i < 4*N; i++) begin
                    if (!out_valid) gaps++;
                    if (!in_ready) drops++;
                    if (i < 4*N-1) @(negedge clk);
                end
            end
        join
        check("stream column gaps", W'(gaps), W'(0));
        check("stream in_ready drops", W'(drops), W'(0));
        drain_all();

        // Backpressure: three blocks against a stalled sink
        out_ready = 1'b0;
        acc0      = acc_count;
        fork
            begin
                for (int i = 0; i < 3*N; i++) send_row(ramp_row(i % N, 37 * (i / N) + 5));
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 300 && (acc_count - acc0) < 2*N; t++) @(negedge clk);
                repeat (3) @(negedge clk);
                check("bp accepted rows", W'(acc_count - acc0), W'(2*N));
                check("bp in_ready low", W'(in_ready), W'(0));
                check("bp row held", W'(in_valid), W'(1));
                @(posedge clk);
                #1 out_ready = 1'b1;
                repeat (N) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("bp in_ready after block read", W'(in_ready), W'(1));
                check("bp no accept while full", W'(acc_count - acc0), W'(2*N));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain_all();

        // Random valid/ready over ten blocks
        src_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10*N; i++) begin
                    idle = 0;
                    while (($urandom % 2) == 1 && idle < 20) begin
                        in_valid = 1'b0;
                        idle++;
                        @(posedge clk);
                        #1;
                    end
                    send_row(rand_row());
                end
                in_valid = 1'b0;
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    out_ready = ($urandom % 2) == 1;
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain_all();

        // Reset mid-operation
        for (int r = 0; r < N; r++) send_row(rand_row());
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int r = 0; r < 7; r++) send_row(rand_row());
        in_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid reset out_valid", W'(out_valid), W'(0));
        check("mid reset in_ready", W'(in_ready), W'(1));
        check("mid reset out_col", out_col, '0);
        check("mid reset out_col_idx", W'(out_col_idx), W'(0));
        sb.delete();
        wr_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < N-1; r++) send_row(ramp_row(r, 100));
        in_valid = 1'b0;
        @(negedge clk);
        check("post reset no stale column", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        send_row(ramp_row(N-1, 100));
        in_valid = 1'b0;
        drain_all();

        // Final write of one bank and final read of the other on the same edge
        for (int r = 0; r < N; r++) send_row(rand_row());
        for (int r = 0; r < N-1; r++) send_row(rand_row());
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (N-1) @(posedge clk);
        #1;
        tmp      = rand_row();
        in_row   = tmp;
        in_valid = 1'b1;
        @(negedge clk);
        check("boundary idx before edge", W'(out_col_idx), W'(N-1));
        check("boundary last before edge", W'(out_last), W'(1));
        check("boundary in_ready before edge", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("boundary out_valid after edge", W'(out_valid), W'(1));
        check("boundary idx after edge", W'(out_col_idx), W'(0));
        check("boundary last after edge", W'(out_last), W'(0));
        check("boundary in_ready after edge", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        drain_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
